// File: rtl/spi_master_pkg.sv
// Shared types for the SPI master: transfer FSM state encoding.
package spi_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// Control-side handshake plus SPI pins of the master, grouped as one bundle.
interface spi_master_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  ss;

  modport master (
    input  start, data_in, miso,
    output data_out, busy, sclk, mosi, ss
  );

  modport slave (
    output start, data_in, miso,
    input  data_out, busy, sclk, mosi, ss
  );

endinterface

// File: rtl/spi_master_clk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV enabled clk cycles and flags the toggle edge.
module spi_clk_gen
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV_WIDTH = 8,
  parameter int CLK_DIV       = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam logic [CLK_DIV_WIDTH-1:0] DIV_LAST = CLK_DIV_WIDTH'(CLK_DIV - 1);

  logic [CLK_DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic                     sclk_q, sclk_d;
  logic                     tc;

  // rise/fall mark the clk edge on which sclk_q is about to change
  always_comb begin
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    tc        = en && (div_cnt_q == DIV_LAST);
    rise      = tc && !sclk_q;
    fall      = tc && sclk_q;
    if (clear) begin
      div_cnt_d = '0;
      sclk_d    = 1'b0;
    end else if (en) begin
      if (tc) begin
        div_cnt_d = '0;
        sclk_d    = !sclk_q;
      end else begin
        div_cnt_d = div_cnt_q + CLK_DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first: shifts one word out on mosi while capturing one from miso.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int CLK_DIV_WIDTH = 8,
  parameter int CLK_DIV       = 2
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.master bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  ss_q, ss_d;
  logic                  busy_q, busy_d;
  logic                  clk_en, clk_clear;
  logic                  sclk, sclk_rise, sclk_fall;

  spi_clk_gen #(
    .CLK_DIV_WIDTH (CLK_DIV_WIDTH),
    .CLK_DIV       (CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .reset (reset),
    .en    (clk_en),
    .clear (clk_clear),
    .sclk  (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // mosi is the MSB of the tx register, so clearing tx_q also parks mosi low
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    dout_d    = dout_q;
    bit_cnt_d = bit_cnt_q;
    ss_d      = ss_q;
    busy_d    = busy_q;
    clk_en    = 1'b0;
    clk_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          tx_d      = bus.data_in;
          ss_d      = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          clk_clear = 1'b1;
          state_d   = ST_XFER;
        end
      end
      ST_XFER: begin
        clk_en = 1'b1;
        if (sclk_rise) begin
          rx_d = {rx_q[DATA_WIDTH-2:0], bus.miso};
        end
        if (sclk_fall) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            tx_d      = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      ST_DONE: begin
        dout_d  = rx_q;
        ss_d    = 1'b1;
        busy_d  = 1'b0;
        tx_d    = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      dout_q    <= '0;
      bit_cnt_q <= '0;
      ss_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      dout_q    <= dout_d;
      bit_cnt_q <= bit_cnt_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.sclk     = sclk;
  assign bus.mosi     = tx_q[DATA_WIDTH-1];
  assign bus.ss       = ss_q;
  assign bus.busy     = busy_q;
  assign bus.data_out = dout_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: timeline model of the transfer plus a mode-0 slave and directed tests.
module tb_spi_master;

  localparam int DW  = 8;
  localparam int DIV = 2;
  localparam int XFER_EDGES = 2 * DW * DIV;

  logic clk;
  logic reset;

  spi_master_if #(.DATA_WIDTH(DW)) bus ();

  spi_master #(
    .DATA_WIDTH    (DW),
    .CLK_DIV_WIDTH (8),
    .CLK_DIV       (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: after the accepting edge, edge number k fixes every output by plain arithmetic
  bit          m_active = 1'b0;
  int          m_k = 0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_rx = '0;
  logic [DW-1:0] m_dout = '0;

  always @(posedge clk) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_dout   <= '0;
    end else if (m_active) begin
      if (m_k + 1 == XFER_EDGES + 1) begin
        m_active <= 1'b0;
        m_dout   <= m_rx;
      end else begin
        m_k <= m_k + 1;
        if (((m_k + 1) % DIV == 0) && (((m_k + 1) / DIV) % 2 == 1))
          m_rx <= {m_rx[DW-2:0], bus.miso};
      end
    end else if (bus.start) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_data   <= bus.data_in;
    end
  end

  logic e_sclk, e_ss, e_busy, e_mosi;
  int   e_h, e_bit;
  always_comb begin
    e_h    = m_k / DIV;
    e_bit  = 0;
    e_sclk = 1'b0;
    e_ss   = 1'b1;
    e_busy = 1'b0;
    e_mosi = 1'b0;
    if (m_active) begin
      e_sclk = (e_h % 2) == 1;
      e_ss   = 1'b0;
      e_busy = 1'b1;
      e_bit  = (e_h / 2 > DW - 1) ? DW - 1 : e_h / 2;
      e_mosi = m_data[DW-1-e_bit];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sclk", bus.sclk, e_sclk);
      check("ss", bus.ss, e_ss);
      check("busy", bus.busy, e_busy);
      check("mosi", bus.mosi, e_mosi);
      check("data_out", bus.data_out, m_dout);
    end
  end

  // Mode-0 slave plus pin monitor
  logic [DW-1:0] slv_q[$];
  logic [DW-1:0] slv_cur = '0;
  int            slv_idx = 0;
  logic          prev_ss = 1'b1;
  logic          prev_sclk = 1'b0;
  logic [DW-1:0] cap = '0;
  int            pulses = 0;
  int            busy_cnt = 0;
  int            ss_lo_cnt = 0;

  always @(negedge clk) begin
    if (prev_ss === 1'b1 && bus.ss === 1'b0) begin
      slv_cur  = (slv_q.size() > 0) ? slv_q.pop_front() : '0;
      slv_idx  = 0;
      bus.miso = slv_cur[DW-1];
    end else if (bus.ss === 1'b0 && prev_sclk === 1'b1 && bus.sclk === 1'b0) begin
      slv_idx++;
      if (slv_idx < DW) bus.miso = slv_cur[DW-1-slv_idx];
    end
    if (prev_sclk === 1'b0 && bus.sclk === 1'b1) begin
      cap = {cap[DW-2:0], bus.mosi};
      pulses++;
    end
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.ss === 1'b0) ss_lo_cnt++;
    prev_ss   = bus.ss;
    prev_sclk = bus.sclk;
  end

  task automatic clear_mon();
    cap       = '0;
    pulses    = 0;
    busy_cnt  = 0;
    ss_lo_cnt = 0;
  endtask

  task automatic pulse_start(input logic [DW-1:0] d);
    @(negedge clk);
    clear_mon();
    bus.data_in = d;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_busy_fall(input string name, input int budget);
    bit seen = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: busy did not fall within %0d clks", name, budget);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.miso    = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_sclk", bus.sclk, 1'b0);
    check("rst_ss", bus.ss, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_data_out", bus.data_out, 8'h00);
    check("rst_mosi", bus.mosi, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Basic transfer and busy/ss window
    slv_q.push_back(8'h55);
    pulse_start(8'hAB);
    wait_busy_fall("basic", 100);
    check("basic_mosi_word", cap, 8'hAB);
    check("basic_pulses", pulses, 8);
    check("basic_data_out", bus.data_out, 8'h55);
    check("basic_busy_clks", busy_cnt, 33);
    check("basic_ss_low_clks", ss_lo_cnt, 33);
    repeat (3) @(negedge clk);

    // Start while busy is ignored
    slv_q.push_back(8'hC3);
    pulse_start(8'hAB);
    repeat (10) @(negedge clk);
    bus.data_in = 8'hFF;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_busy_fall("busy_start", 100);
    check("busy_start_mosi_word", cap, 8'hAB);
    check("busy_start_pulses", pulses, 8);
    check("busy_start_data_out", bus.data_out, 8'hC3);
    repeat (3) @(negedge clk);
    check("busy_start_idle", bus.busy, 1'b0);

    // Back-to-back with start held high
    slv_q.push_back(8'h00);
    slv_q.push_back(8'hFF);
    @(negedge clk);
    clear_mon();
    bus.data_in = 8'h3C;
    bus.start   = 1'b1;
    wait_busy_fall("b2b_first", 100);
    check("b2b_first_data_out", bus.data_out, 8'h00);
    check("b2b_first_mosi_word", cap, 8'h3C);
    gap = 0;
    while (bus.ss === 1'b1 && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("b2b_ss_gap_ge1", (gap >= 1) ? 1 : 0, 1);
    check("b2b_ss_gap_bounded", (gap < 10) ? 1 : 0, 1);
    wait_busy_fall("b2b_second", 100);
    check("b2b_second_data_out", bus.data_out, 8'hFF);
    check("b2b_total_pulses", pulses, 16);
    repeat (3) @(negedge clk);

    // Abort after four sclk pulses
    apply_reset();
    @(negedge clk);
    slv_q.push_back(8'h55);
    pulse_start(8'hAB);
    for (int i = 0; i < 100 && !(pulses == 4 && bus.sclk === 1'b0); i++) @(negedge clk);
    check("abort_reached_4_pulses", pulses, 4);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_sclk", bus.sclk, 1'b0);
    check("abort_ss", bus.ss, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_mosi", bus.mosi, 1'b0);
    check("abort_data_out", bus.data_out, 8'h00);
    repeat (5) @(negedge clk);
    check("abort_data_out_hold", bus.data_out, 8'h00);
    check("abort_pulses_stopped", pulses, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
